rs232_rx_fifo: RTL and testbench
================================

# rs232_rx_fifo

Receive-side buffer between the RS-232 receiver and the CPU I/O bus. It drains each completed byte from the receiver into a small FIFO, so bursts at the fast bitrate survive software latency. The CPU reads bytes at I/O word 2 and polls status at I/O word 3. The top level drives `pop` from `rd & ioenb & (iowadr == 2)` and `clr_ovf` from `wr & ioenb & (iowadr == 3) & outbus[1]`. The block replaces the direct `dataRx`/`rdyRx`/`doneRx` connection.

## Interface
- `AW`, default 4: log2 of FIFO depth. Depth is `DEPTH = 2**AW` entries of 8 bits.
- `clk` in 1: system clock. Only clock in the block.
- `rst` in 1: asynchronous, active-high reset.
- `rx_rdy` in 1: receiver holds a completed byte. Level; stays high until acknowledged.
- `rx_data` in 8: receiver byte. Valid while `rx_rdy` is high.
- `rx_done` out 1: one-cycle acknowledge to the receiver, which clears `rx_rdy`.
- `pop` in 1: CPU read strobe. Removes the head byte.
- `clr_ovf` in 1: clears the sticky overflow flag.
- `dout` out 8: head byte. Forced to 0 when the FIFO is empty.
- `rdy` out 1: FIFO not empty.
- `count` out AW+1: number of stored bytes, 0..DEPTH.
- `ovf` out 1: sticky flag; a byte was dropped because the FIFO was full.

## Operation
- Storage: DEPTH x 8 array with write pointer `wp` and read pointer `rp`, each AW bits. Pointers wrap modulo DEPTH. Occupancy is tracked in `count` (AW+1 bits), not derived from the pointers.
- Capture FSM has two states, IDLE and ACK.
  - IDLE, `rx_rdy`=1: take the byte (push or drop, see below), set `rx_done`=1 for the next cycle, go to ACK.
  - IDLE, `rx_rdy`=0: stay in IDLE.
  - ACK: `rx_done`=0. Stay in ACK while `rx_rdy`=1; go to IDLE when `rx_rdy`=0. This prevents double capture while the receiver's `rdy` falls.
- Push is accepted when `count < DEPTH`, or when `pop` is asserted in the same cycle.
  - Accepted: write `mem[wp] <= rx_data`, then `wp <= wp+1`.
  - Not accepted: discard the byte, set `ovf` <= 1, still pulse `rx_done`.
- Pop when `count == 0` is ignored: no pointer change, no underflow.
- Pop when non-empty: `rp <= rp+1`.
- Count update:
  - push only: +1
  - pop only: −1
  - both in the same cycle: unchanged
  - neither: unchanged
- `rdy = (count != 0)`. `dout = rdy ? mem[rp] : 0`, a combinational read of the array.
- Overflow flag:
  - `clr_ovf` clears `ovf`.
  - If a drop and `clr_ovf` occur in the same cycle, the set wins and `ovf` = 1.
- Reset (asynchronous, any time, including during ACK or mid-burst):
  - `wp`=`rp`=0, `count`=0, `ovf`=0, FSM=IDLE, `rx_done`=0.
  - Array contents are not reset; `dout`=0 because the FIFO is empty.
  - A receiver byte still pending at reset release is captured normally from IDLE.

## Timing
- Reset values: `rx_done`=0, `rdy`=0, `count`=0, `ovf`=0, `dout`=0.
- Capture latency: `rx_rdy` high at edge k (FSM in IDLE) gives:
  - byte written and `count` incremented at edge k;
  - `rdy`/`dout` valid in the cycle after edge k;
  - `rx_done` high for exactly the cycle between edges k and k+1.
- Maximum intake is one byte per 2 cycles (IDLE→ACK→IDLE). This is far above the line rate.
- Pop latency:
  - `pop` sampled at edge m; the next head appears on `dout` after edge m.
  - A CPU load at I/O word 2 therefore samples the current head combinationally in the `pop` cycle.
- `count` and `ovf` are registered outputs; `rdy` and `dout` are combinational from registers only.
- No combinational path from `pop` or `rx_rdy` to any output.

## Test plan
- Reset then single byte: assert `rst` for 3 cycles. Then drive `rx_data`=0x5A with `rx_rdy`=1 until `rx_done`. Required: exactly one `rx_done` pulse; `rdy`=1, `dout`=0x5A, `count`=1. `pop` one cycle -> `rdy`=0, `dout`=0, `count`=0.
- Fill and overflow (AW=4): push 0x00..0x0F -> `count`=16, `ovf`=0. Push 0xEE -> `rx_done` still pulses, `count`=16, `ovf`=1. Popping 16 times returns 0x00..0x0F in order; 0xEE never appears.
- Simultaneous push/pop at full: with 16 bytes stored, push 0x77 in the same cycle as a pop -> `count` stays 16, `ovf` stays 0. Draining returns 0x01..0x0F, then 0x77.
- Pointer wrap: 40 alternating push/pop pairs of an incrementing byte, with occupancy between 1 and 3 -> every byte is read in order and `count` never exceeds 3.
- `ovf` priority and empty pop: drop and `clr_ovf` in the same cycle -> `ovf`=1. `clr_ovf` alone -> `ovf`=0. `pop` while empty -> `count`=0, pointers unchanged; the next push then reads back correctly.
- Reset mid-operation: assert `rst` asynchronously (between edges) while in ACK with 5 bytes stored -> outputs go to reset values immediately; after release, a held `rx_rdy` byte 0x3C is captured as the sole entry.

Source files
------------

// File: rtl/rs232_rx_fifo.sv
// Receive FIFO between the RS-232 receiver and the CPU I/O bus.
// Captures each completed receiver byte once, buffers it, and flags dropped bytes.
module rs232_rx_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_rdy,
    input  logic [7:0]    rx_data,
    output logic          rx_done,
    input  logic          pop,
    input  logic          clr_ovf,
    output logic [7:0]    dout,
    output logic          rdy,
    output logic [AW:0]   count,
    output logic          ovf
);

    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO = '0;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [0:0]    state;
    logic [0:0]    state_d;

    logic capture;
    logic pop_ok;
    logic push_ok;
    logic drop;

    always_comb begin
        capture = (state == ST_IDLE) && rx_rdy;
        pop_ok  = pop && (count != CNT_ZERO);
        // A pop in the same cycle frees the slot the incoming byte needs.
        push_ok = capture && ((count < CNT_FULL) || pop_ok);
        drop    = capture && !push_ok;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (rx_rdy)  state_d = ST_ACK;
            ST_ACK:  if (!rx_rdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            rx_done <= 1'b0;
        end else begin
            state   <= state_d;
            rx_done <= capture;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) wp <= wp + PTR_ONE;
            if (pop_ok)  rp <= rp + PTR_ONE;
            if (push_ok && !pop_ok) begin
                count <= count + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Set beats clear so a drop coinciding with a clear is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= rx_data;
    end

    always_comb begin
        rdy  = (count != CNT_ZERO);
        dout = rdy ? mem[rp] : 8'h00;
    end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Bench for rs232_rx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_rs232_rx_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx_rdy = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_done;
    logic         pop = 1'b0;
    logic         clr_ovf = 1'b0;
    logic [7:0]   dout;
    logic         rdy;
    logic [AW:0]  count;
    logic         ovf;

    rs232_rx_fifo #(.AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .pop     (pop),
        .clr_ovf (clr_ovf),
        .dout    (dout),
        .rdy     (rdy),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: byte queue, sticky flag, and whether the receiver line has
    // been seen idle since the last capture (a byte is taken once per rx_rdy episode).
    byte unsigned q[$];
    bit m_ovf, m_done, armed, m_cap, m_pop, m_drop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf  = 1'b0;
            m_done = 1'b0;
            armed  = 1'b1;
        end else begin
            m_cap  = armed && rx_rdy;
            m_pop  = pop && (q.size() > 0);
            m_drop = m_cap && (q.size() == DEPTH) && !m_pop;
            if (m_pop) void'(q.pop_front());
            if (m_cap && !m_drop) q.push_back(rx_data);
            if (m_drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_done = m_cap;
            if (m_cap) armed = 1'b0;
            else if (!rx_rdy) armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("count", 32'(count), 32'(q.size()));
            check("rdy", 32'(rdy), 32'(q.size() != 0));
            check("dout", 32'(dout), (q.size() != 0) ? 32'(q[0]) : 32'd0);
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("rx_done", 32'(rx_done), 32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One receiver byte: capture edge (optionally with pop/clear), then line drops.
    task automatic push(input logic [7:0] b, input logic with_pop, input logic with_clr);
        rx_rdy  = 1'b1;
        rx_data = b;
        pop     = with_pop;
        clr_ovf = with_clr;
        tick();
        pop     = 1'b0;
        clr_ovf = 1'b0;
        check("push_ack", 32'(rx_done), 32'd1);
        rx_rdy  = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input logic [7:0] b);
        check("pop_head", 32'(dout), 32'(b));
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    int got;
    int pop_pct;
    logic [7:0] nb;

    initial begin
        #2 rst = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_count", 32'(count), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_rdy", 32'(rdy), 32'd0);

        // Single byte, held until acknowledged.
        rx_rdy = 1'b1; rx_data = 8'h5A; got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            tick();
            if (rx_done) got = 1;
        end
        check("first_ack_seen", 32'(got), 32'd1);
        rx_rdy = 1'b0;
        tick();
        check("ack_single_pulse", 32'(rx_done), 32'd0);
        tick();
        check("ack_stays_low", 32'(rx_done), 32'd0);
        check("single_rdy", 32'(rdy), 32'd1);
        check("single_dout", 32'(dout), 32'h5A);
        check("single_count", 32'(count), 32'd1);
        pop = 1'b1; tick(); pop = 1'b0;
        check("after_pop_rdy", 32'(rdy), 32'd0);
        check("after_pop_dout", 32'(dout), 32'd0);
        check("after_pop_count", 32'(count), 32'd0);

        // Fill, overflow, flag priority, drain.
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd16);
        check("full_ovf", 32'(ovf), 32'd0);
        push(8'hEE, 1'b0, 1'b0);
        check("drop_count", 32'(count), 32'd16);
        check("drop_ovf", 32'(ovf), 32'd1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);
        push(8'hEF, 1'b0, 1'b1);
        check("drop_beats_clr", 32'(ovf), 32'd1);
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        check("clr_alone", 32'(ovf), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_expect(8'(i));
        check("drained_count", 32'(count), 32'd0);

        // Empty pop is ignored; next push still reads back.
        pop = 1'b1; tick(); pop = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);
        push(8'hA5, 1'b0, 1'b0);
        check("after_empty_pop_dout", 32'(dout), 32'hA5);
        pop_expect(8'hA5);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0, 1'b0);
        check("simul_head", 32'(dout), 32'h00);
        push(8'h77, 1'b1, 1'b0);
        check("simul_count", 32'(count), 32'd16);
        check("simul_ovf", 32'(ovf), 32'd0);
        for (int i = 1; i < DEPTH; i++) pop_expect(8'(i));
        pop_expect(8'h77);

        // Pointer wrap with low occupancy.
        nb = 8'h80;
        push(8'h80, 1'b0, 1'b0);
        push(8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h82 + i), 1'b0, 1'b0);
            check("wrap_count_le3", 32'(count <= 5'd3), 32'd1);
            pop_expect(nb);
            nb = nb + 8'd1;
        end
        pop_expect(nb);
        pop_expect(nb + 8'd1);

        // Randomized traffic alternating slow and fast CPU drain rates.
        pop_pct = 15;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) pop_pct = ((i / 500) % 2 == 0) ? 15 : 70;
            if (rx_rdy && rx_done) rx_rdy = 1'b0;
            else if (!rx_rdy && $urandom_range(0, 2) == 0) begin
                rx_rdy  = 1'b1;
                rx_data = 8'($urandom);
            end
            pop     = ($urandom_range(0, 99) < pop_pct);
            clr_ovf = ($urandom_range(0, 31) == 0);
            tick();
        end
        rx_rdy = 1'b0; pop = 1'b0; clr_ovf = 1'b0;
        tick(); tick();

        // Asynchronous reset while in ACK with five bytes stored.
        do_reset();
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 1'b0, 1'b0);
        rx_rdy = 1'b1; rx_data = 8'h14;
        tick();
        check("pre_reset_count", 32'(count), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_rdy", 32'(rdy), 32'd0);
        check("async_dout", 32'(dout), 32'd0);
        check("async_done", 32'(rx_done), 32'd0);
        rx_data = 8'h3C;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("post_reset_ack", 32'(rx_done), 32'd1);
        rx_rdy = 1'b0;
        tick();
        check("post_reset_count", 32'(count), 32'd1);
        check("post_reset_dout", 32'(dout), 32'h3C);
        pop_expect(8'h3C);
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
